// File: rtl/link_pkg.sv
// Shared link-layer definitions: K-code symbols, framer state encoding and
// ordered-set type encoding with a decode helper.
package link_pkg;

    localparam logic [7:0] K_STP = 8'hfb;
    localparam logic [7:0] K_SDP = 8'h5c;
    localparam logic [7:0] K_END = 8'hfd;
    localparam logic [7:0] K_EDB = 8'hfe;
    localparam logic [7:0] K_SKP = 8'h1c;
    localparam logic [7:0] K_IDL = 8'h7c;
    localparam logic [7:0] K_FTS = 8'h3c;
    localparam logic [7:0] K_COM = 8'hbc;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_OS   = 2'd2
    } framer_state_e;

    typedef enum logic [1:0] {
        OS_SKP = 2'd0,
        OS_FTS = 2'd1,
        OS_IDL = 2'd2
    } os_type_e;

    typedef struct packed {
        logic     hit;
        os_type_e kind;
    } os_sym_t;

    function automatic os_sym_t os_decode(input logic [7:0] code);
        os_sym_t r;
        r.hit  = 1'b1;
        r.kind = OS_SKP;
        case (code)
            K_SKP:   r.kind = OS_SKP;
            K_FTS:   r.kind = OS_FTS;
            K_IDL:   r.kind = OS_IDL;
            default: r.hit  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rx_framer_if.sv
// Byte stream in / framed packet and ordered-set events out.
// slave is the framer's view, master is the upstream/consumer view.
interface rx_framer_if #(parameter int LEN_W = 7);
    logic             valid_in;
    logic [7:0]       data_in;
    logic [7:0]       control_in;
    logic             pkt_valid;
    logic [7:0]       pkt_data;
    logic             pkt_sop;
    logic             pkt_eop;
    logic             pkt_err;
    logic             pkt_type;
    logic [LEN_W-1:0] pkt_len;
    logic             os_valid;
    logic [1:0]       os_type;
    logic             framing_err;

    modport slave (
        input  valid_in, data_in, control_in,
        output pkt_valid, pkt_data, pkt_sop, pkt_eop, pkt_err, pkt_type, pkt_len,
        output os_valid, os_type, framing_err
    );

    modport master (
        output valid_in, data_in, control_in,
        input  pkt_valid, pkt_data, pkt_sop, pkt_eop, pkt_err, pkt_type, pkt_len,
        input  os_valid, os_type, framing_err
    );
endinterface

// File: rtl/framer_os_detect.sv
// COM-led ordered-set matcher: after start, expects three identical
// SKP/FTS/IDL symbols; flags done on the third and mismatch on anything else.
module framer_os_detect
    import link_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sym_valid,
    input  logic [7:0] sym,
    output logic       done,
    output os_type_e   os_type,
    output logic       mismatch
);

    logic [1:0] cnt_r;
    os_type_e   type_r;
    os_sym_t    dec_s;
    logic       match_s;

    // Classify the current symbol against the latched ordered-set type.
    always_comb begin
        dec_s = os_decode(sym);
        if (cnt_r == 2'd0) begin
            match_s = dec_s.hit;
        end else begin
            match_s = dec_s.hit && (dec_s.kind == type_r);
        end
        done     = sym_valid && match_s && (cnt_r == 2'd2);
        mismatch = sym_valid && !match_s;
        os_type  = type_r;
    end

    // Match counter and latched type; a fresh COM restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= 2'd0;
            type_r <= OS_SKP;
        end else if (start) begin
            cnt_r <= 2'd0;
        end else if (sym_valid) begin
            if (match_s && (cnt_r != 2'd2)) begin
                cnt_r <= cnt_r + 2'd1;
                if (cnt_r == 2'd0) begin
                    type_r <= dec_s.kind;
                end
            end else begin
                cnt_r <= 2'd0;
            end
        end
    end

endmodule

// File: rtl/rx_framer.sv
// Receive framer: STP/SDP..END/EDB packets to byte beats, COM ordered sets to events.
// Optional RX_FRAMER_STATS_EN adds saturating pkt_count / err_count outputs.
module rx_framer
    import link_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    rx_framer_if.slave  bus
`ifdef RX_FRAMER_STATS_EN
    ,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count
`endif
);

    framer_state_e    state_r, nxt_state_s;
    logic [7:0]       hold_r;
    logic             hold_full_r, hold_first_r;
    logic [LEN_W-1:0] len_r;
    logic             type_r;

    logic beat_s, eop_s, bad_s, ferr_s, load_s, drop_s;
    logic pkt_start_s, os_start_s, os_fire_s, idle_proc_s;
    logic is_data_s, is_end_s, is_pkt_k_s;
    logic os_done_s, os_mismatch_s;
    os_type_e os_kind_s;

    assign is_data_s  = (bus.control_in == 8'h00);
    assign is_end_s   = (bus.control_in == K_END) || (bus.control_in == K_EDB);
    assign is_pkt_k_s = (bus.control_in == K_STP) || (bus.control_in == K_SDP);

    framer_os_detect u_os_detect (
        .clk       (clk),
        .reset     (reset),
        .start     (os_start_s),
        .sym_valid (bus.valid_in && (state_r == ST_OS)),
        .sym       (bus.control_in),
        .done      (os_done_s),
        .os_type   (os_kind_s),
        .mismatch  (os_mismatch_s)
    );

    // Next-state and per-cycle action decode; IDLE handling is shared so a
    // terminating K-code in PKT/OS can be re-interpreted in the same cycle.
    always_comb begin
        nxt_state_s = state_r;
        beat_s      = 1'b0;
        eop_s       = 1'b0;
        bad_s       = 1'b0;
        ferr_s      = 1'b0;
        load_s      = 1'b0;
        drop_s      = 1'b0;
        pkt_start_s = 1'b0;
        os_start_s  = 1'b0;
        os_fire_s   = 1'b0;
        idle_proc_s = 1'b0;
        if (bus.valid_in) begin
            case (state_r)
                ST_IDLE: idle_proc_s = 1'b1;
                ST_PKT: begin
                    if (is_data_s) begin
                        beat_s = hold_full_r;
                        if (len_r == LEN_W'(MAX_LEN)) begin
                            eop_s       = 1'b1;
                            bad_s       = 1'b1;
                            ferr_s      = 1'b1;
                            drop_s      = 1'b1;
                            nxt_state_s = ST_IDLE;
                        end else begin
                            load_s = 1'b1;
                        end
                    end else if (is_end_s) begin
                        drop_s      = 1'b1;
                        nxt_state_s = ST_IDLE;
                        if (hold_full_r) begin
                            beat_s = 1'b1;
                            eop_s  = 1'b1;
                            bad_s  = (bus.control_in == K_EDB);
                        end else begin
                            ferr_s = 1'b1;
                        end
                    end else begin
                        beat_s      = hold_full_r;
                        eop_s       = 1'b1;
                        bad_s       = 1'b1;
                        ferr_s      = 1'b1;
                        drop_s      = 1'b1;
                        nxt_state_s = ST_IDLE;
                        idle_proc_s = is_pkt_k_s || (bus.control_in == K_COM);
                    end
                end
                ST_OS: begin
                    if (os_done_s) begin
                        os_fire_s   = 1'b1;
                        nxt_state_s = ST_IDLE;
                    end else if (os_mismatch_s) begin
                        ferr_s      = 1'b1;
                        nxt_state_s = ST_IDLE;
                        idle_proc_s = 1'b1;
                    end else begin
                        nxt_state_s = ST_OS;
                    end
                end
                default: nxt_state_s = ST_IDLE;
            endcase
            if (idle_proc_s) begin
                if (is_pkt_k_s) begin
                    pkt_start_s = 1'b1;
                    nxt_state_s = ST_PKT;
                end else if (bus.control_in == K_COM) begin
                    os_start_s  = 1'b1;
                    nxt_state_s = ST_OS;
                end else if (is_data_s) begin
                    nxt_state_s = ST_IDLE;
                end else begin
                    ferr_s      = 1'b1;
                    nxt_state_s = ST_IDLE;
                end
            end else begin
                os_start_s = 1'b0;
            end
        end else begin
            nxt_state_s = state_r;
        end
    end

    // State, hold register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            hold_r          <= 8'h00;
            hold_full_r     <= 1'b0;
            hold_first_r    <= 1'b0;
            len_r           <= {LEN_W{1'b0}};
            type_r          <= 1'b0;
            bus.pkt_valid   <= 1'b0;
            bus.pkt_data    <= 8'h00;
            bus.pkt_sop     <= 1'b0;
            bus.pkt_eop     <= 1'b0;
            bus.pkt_err     <= 1'b0;
            bus.pkt_type    <= 1'b0;
            bus.pkt_len     <= {LEN_W{1'b0}};
            bus.os_valid    <= 1'b0;
            bus.os_type     <= 2'd0;
            bus.framing_err <= 1'b0;
        end else begin
            state_r         <= nxt_state_s;
            bus.pkt_valid   <= beat_s;
            bus.pkt_data    <= beat_s ? hold_r : 8'h00;
            bus.pkt_sop     <= beat_s && hold_first_r;
            bus.pkt_eop     <= beat_s && eop_s;
            bus.pkt_err     <= beat_s && eop_s && bad_s;
            bus.pkt_len     <= (beat_s && eop_s) ? len_r : {LEN_W{1'b0}};
            bus.os_valid    <= os_fire_s;
            bus.framing_err <= ferr_s;
            if (beat_s) begin
                bus.pkt_type <= type_r;
            end
            if (os_fire_s) begin
                bus.os_type <= os_kind_s;
            end
            if (drop_s) begin
                hold_full_r <= 1'b0;
            end else if (load_s) begin
                hold_r       <= bus.data_in;
                hold_full_r  <= 1'b1;
                hold_first_r <= !hold_full_r;
                len_r        <= len_r + LEN_W'(1'b1);
            end
            if (pkt_start_s) begin
                type_r <= (bus.control_in == K_SDP);
                len_r  <= {LEN_W{1'b0}};
            end
        end
    end

`ifdef RX_FRAMER_STATS_EN
    logic [16:0] err_sum_s;
    assign err_sum_s = {1'b0, err_count} + 17'(ferr_s) + 17'(beat_s && eop_s && bad_s);

    // Saturating good-packet and error-event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= 16'h0000;
            err_count <= 16'h0000;
        end else begin
            if (beat_s && eop_s && !bad_s && (pkt_count != 16'hffff)) begin
                pkt_count <= pkt_count + 16'h0001;
            end
            err_count <= err_sum_s[16] ? 16'hffff : err_sum_s[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_rx_framer.sv
// Self-checking bench for rx_framer: directed vector table, reset sequence and
// randomized symbol streams checked against a queue-based packet model.
module tb_rx_framer;
    import link_pkg::*;

    localparam int MAXL  = 4;
    localparam int LEN_W = 7;

    typedef struct packed {
        logic       pv;
        logic [7:0] pd;
        logic       sop;
        logic       eop;
        logic       err;
        logic       pt;
        logic [6:0] plen;
        logic       osv;
        logic [1:0] ost;
        logic       ferr;
    } exp_t;

    typedef struct {
        string      nm;
        logic       v;
        logic [7:0] c;
        logic [7:0] d;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    logic [7:0] sym_c[$];
    logic [7:0] sym_d[$];

    rx_framer_if #(.LEN_W(LEN_W)) bus ();
`ifdef RX_FRAMER_STATS_EN
    logic [15:0] pkt_count, err_count;
`endif

    rx_framer #(.MAX_LEN(MAXL), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef RX_FRAMER_STATS_EN
        ,
        .pkt_count (pkt_count),
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         md = 0;
    logic [7:0] q[$];
    logic       mptype = 1'b0;
    logic [7:0] os_sym = 8'h00;
    int         os_n = 0;
    int         m_pkt = 0;
    int         m_err = 0;

    function automatic logic is_os(input logic [7:0] c);
        return (c == K_SKP) || (c == K_FTS) || (c == K_IDL);
    endfunction

    function automatic logic [1:0] os_code(input logic [7:0] c);
        return (c == K_FTS) ? 2'd1 : (c == K_IDL) ? 2'd2 : 2'd0;
    endfunction

    task automatic m_idle(input logic [7:0] c, inout exp_t e);
        if (c == K_STP || c == K_SDP) begin
            md = 1; q.delete(); mptype = (c == K_SDP);
        end else if (c == K_COM) begin
            md = 2; os_n = 0;
        end else if (c != 8'h00) begin
            e.ferr = 1'b1;
        end
    endtask

    task automatic m_emit(inout exp_t e, input logic last, input logic bad);
        e.pv   = 1'b1;
        e.pd   = q[q.size()-1];
        e.sop  = (q.size() == 1);
        e.eop  = last;
        e.err  = last && bad;
        e.pt   = mptype;
        e.plen = last ? 7'(q.size()) : 7'd0;
    endtask

    task automatic m_step(input logic [7:0] c, input logic [7:0] d, output exp_t e);
        e = '0;
        if (md == 1) begin
            if (c == 8'h00) begin
                if (q.size() == MAXL) begin
                    m_emit(e, 1'b1, 1'b1); e.ferr = 1'b1; md = 0;
                end else begin
                    if (q.size() > 0) m_emit(e, 1'b0, 1'b0);
                    q.push_back(d);
                end
            end else if (c == K_END || c == K_EDB) begin
                if (q.size() > 0) m_emit(e, 1'b1, c == K_EDB);
                else e.ferr = 1'b1;
                md = 0;
            end else begin
                if (q.size() > 0) m_emit(e, 1'b1, 1'b1);
                e.ferr = 1'b1; md = 0;
                if (c == K_STP || c == K_SDP || c == K_COM) m_idle(c, e);
            end
        end else if (md == 2) begin
            if (is_os(c) && (os_n == 0 || c == os_sym)) begin
                os_sym = c; os_n++;
                if (os_n == 3) begin
                    e.osv = 1'b1; e.ost = os_code(c); md = 0;
                end
            end else begin
                e.ferr = 1'b1; md = 0; m_idle(c, e);
            end
        end else begin
            m_idle(c, e);
        end
        if (e.pv && e.eop && !e.err) m_pkt++;
        m_err += int'(e.ferr) + int'(e.pv && e.eop && e.err);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare_out(input string nm, input exp_t e);
        chk({nm, ".pkt_valid"}, 32'(bus.pkt_valid), 32'(e.pv));
        chk({nm, ".framing_err"}, 32'(bus.framing_err), 32'(e.ferr));
        chk({nm, ".os_valid"}, 32'(bus.os_valid), 32'(e.osv));
        chk({nm, ".pkt_sop"}, 32'(bus.pkt_sop), 32'(e.sop));
        chk({nm, ".pkt_eop"}, 32'(bus.pkt_eop), 32'(e.eop));
        if (e.pv) begin
            chk({nm, ".pkt_data"}, 32'(bus.pkt_data), 32'(e.pd));
            chk({nm, ".pkt_type"}, 32'(bus.pkt_type), 32'(e.pt));
        end
        if (e.pv && e.eop) begin
            chk({nm, ".pkt_err"}, 32'(bus.pkt_err), 32'(e.err));
            chk({nm, ".pkt_len"}, 32'(bus.pkt_len), 32'(e.plen));
        end
        if (e.osv) chk({nm, ".os_type"}, 32'(bus.os_type), 32'(e.ost));
    endtask

    task automatic apply(input string nm, input logic v, input logic [7:0] c,
                         input logic [7:0] d, input exp_t e);
        bus.valid_in = v; bus.control_in = c; bus.data_in = d;
        @(posedge clk);
        #1;
        compare_out(nm, e);
    endtask

    task automatic do_reset();
        bus.valid_in = 1'b0; bus.control_in = 8'h00; bus.data_in = 8'h00;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        md = 0; q.delete(); os_n = 0; m_pkt = 0; m_err = 0;
    endtask

    function automatic exp_t nb();
        return '0;
    endfunction

    function automatic exp_t bt(input logic [7:0] d, input logic s, input logic eo,
                                input logic er, input logic t, input int len, input logic fe);
        exp_t e = '0;
        e.pv = 1'b1; e.pd = d; e.sop = s; e.eop = eo; e.err = er;
        e.pt = t; e.plen = 7'(len); e.ferr = fe;
        return e;
    endfunction

    function automatic exp_t fe();
        exp_t e = '0;
        e.ferr = 1'b1;
        return e;
    endfunction

    function automatic exp_t osev(input logic [1:0] t);
        exp_t e = '0;
        e.osv = 1'b1; e.ost = t;
        return e;
    endfunction

    task automatic add(input string nm, input logic v, input logic [7:0] c,
                       input logic [7:0] d, input exp_t e);
        vec_t x;
        x.nm = nm; x.v = v; x.c = c; x.d = d; x.e = e;
        vecs.push_back(x);
    endtask

    task automatic kd(input string nm, input logic [7:0] d, input exp_t e);
        add(nm, 1'b1, 8'h00, d, e);
    endtask

    task automatic kk(input string nm, input logic [7:0] c, input exp_t e);
        add(nm, 1'b1, c, 8'h00, e);
    endtask

    initial begin
        exp_t e;
        logic [7:0] kall[8] = '{K_STP, K_SDP, K_END, K_EDB, K_SKP, K_IDL, K_FTS, K_COM};
        logic [7:0] kos[3]  = '{K_SKP, K_FTS, K_IDL};

        // 3-byte TLP with an idle gap
        kk("t1", K_STP, nb()); kd("t1", 8'h11, nb()); add("t1gap", 1'b0, 8'h00, 8'h00, nb());
        kd("t1", 8'h22, bt(8'h11, 1, 0, 0, 0, 0, 0)); kd("t1", 8'h33, bt(8'h22, 0, 0, 0, 0, 0, 0));
        kk("t1end", K_END, bt(8'h33, 0, 1, 0, 0, 3, 0));
        // single-byte nullified DLLP
        kk("t2", K_SDP, nb()); kd("t2", 8'haa, nb());
        kk("t2edb", K_EDB, bt(8'haa, 1, 1, 1, 1, 1, 0));
        // STP inside a packet flushes with error and starts a new packet
        kk("t3", K_STP, nb()); kd("t3", 8'h01, nb()); kd("t3", 8'h02, bt(8'h01, 1, 0, 0, 0, 0, 0));
        kk("t3stp", K_STP, bt(8'h02, 0, 1, 1, 0, 2, 1)); kd("t3", 8'h03, nb());
        kk("t3end", K_END, bt(8'h03, 1, 1, 0, 0, 1, 0));
        // good SKP ordered set, then an FTS mismatch
        kk("t4", K_COM, nb()); kk("t4", K_SKP, nb()); kk("t4", K_SKP, nb());
        kk("t4skp", K_SKP, osev(2'd0));
        kk("t4b", K_COM, nb()); kk("t4b", K_IDL, nb()); kk("t4b", K_IDL, nb());
        kk("t4bfts", K_FTS, fe());
        kk("t4c", K_STP, nb()); kd("t4c", 8'h77, nb());
        kk("t4cend", K_END, bt(8'h77, 1, 1, 0, 0, 1, 0));
        // overflow at MAX_LEN+1, END afterwards is a framing error
        kk("t5", K_STP, nb()); kd("t5", 8'ha1, nb()); kd("t5", 8'ha2, bt(8'ha1, 1, 0, 0, 0, 0, 0));
        kd("t5", 8'ha3, bt(8'ha2, 0, 0, 0, 0, 0, 0)); kd("t5", 8'ha4, bt(8'ha3, 0, 0, 0, 0, 0, 0));
        kd("t5ovf", 8'ha5, bt(8'ha4, 0, 1, 1, 0, 4, 1)); kk("t5end", K_END, fe());
        // exactly MAX_LEN bytes is legal
        kk("t5b", K_SDP, nb()); kd("t5b", 8'hb1, nb()); kd("t5b", 8'hb2, bt(8'hb1, 1, 0, 0, 1, 0, 0));
        kd("t5b", 8'hb3, bt(8'hb2, 0, 0, 0, 1, 0, 0)); kd("t5b", 8'hb4, bt(8'hb3, 0, 0, 0, 1, 0, 0));
        kk("t5bend", K_END, bt(8'hb4, 0, 1, 0, 1, 4, 0));
        // COM in a packet: flush plus entry into ordered-set matching
        kk("t6", K_STP, nb()); kd("t6", 8'h55, nb()); kk("t6com", K_COM, bt(8'h55, 1, 1, 1, 0, 1, 1));
        kk("t6", K_FTS, nb()); kk("t6", K_FTS, nb()); kk("t6fts", K_FTS, osev(2'd1));
        // IDLE-state violations and zero-length packet
        kk("t7end", K_END, fe()); kd("t7drop", 8'h99, nb());
        kk("t7", K_SDP, nb()); kk("t7zero", K_END, fe());
        kk("t8", K_STP, nb()); kd("t8", 8'hc1, nb()); kd("t8", 8'hc2, bt(8'hc1, 1, 0, 0, 0, 0, 0));
        kk("t8idl", K_IDL, bt(8'hc2, 0, 1, 1, 0, 2, 1)); kd("t8drop", 8'hc3, nb());

        do_reset();
        compare_out("reset", nb());
        chk("reset.pkt_len", 32'(bus.pkt_len), 32'd0);
        foreach (vecs[i]) apply(vecs[i].nm, vecs[i].v, vecs[i].c, vecs[i].d, vecs[i].e);

        // asynchronous reset mid-packet
        apply("r", 1'b1, K_STP, 8'h00, nb()); apply("r", 1'b1, 8'h00, 8'h11, nb());
        apply("r", 1'b1, 8'h00, 8'h22, bt(8'h11, 1, 0, 0, 0, 0, 0));
        bus.valid_in = 1'b0;
        reset = 1'b1;
        #2;
        chk("async.all", {bus.pkt_valid, bus.pkt_data, bus.pkt_sop, bus.pkt_eop, bus.pkt_err,
            bus.pkt_type, bus.pkt_len, bus.os_valid, bus.os_type, bus.framing_err}, 32'd0);
`ifdef RX_FRAMER_STATS_EN
        chk("async.pkt_count", 32'(pkt_count), 32'd0);
        chk("async.err_count", 32'(err_count), 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        apply("r.end", 1'b1, K_END, 8'h00, fe());

        // randomized symbol streams
        do_reset();
        for (int s = 0; s < 500; s++) begin
            int r = $urandom_range(0, 9);
            if (r < 5) begin
                int n = $urandom_range(0, 6);
                sym_c.push_back(($urandom_range(0, 1) == 0) ? K_STP : K_SDP); sym_d.push_back(8'h00);
                for (int k = 0; k < n; k++) begin
                    sym_c.push_back(8'h00); sym_d.push_back(8'($urandom));
                end
                sym_c.push_back(($urandom_range(0, 4) == 0) ? kall[$urandom_range(0, 7)]
                                : (($urandom_range(0, 2) == 0) ? K_EDB : K_END));
                sym_d.push_back(8'h00);
            end else if (r < 8) begin
                logic [7:0] t = kos[$urandom_range(0, 2)];
                sym_c.push_back(K_COM); sym_d.push_back(8'h00);
                for (int k = 0; k < 3; k++) begin
                    int p = $urandom_range(0, 9);
                    sym_c.push_back((p == 0) ? 8'h00 : (p == 1) ? kall[$urandom_range(0, 7)] : t);
                    sym_d.push_back(8'($urandom));
                end
            end else begin
                sym_c.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : kall[$urandom_range(0, 7)]);
                sym_d.push_back(8'($urandom));
            end
        end
        foreach (sym_c[i]) begin
            if ($urandom_range(0, 4) == 0) apply("rnd.gap", 1'b0, 8'h00, 8'h00, nb());
            m_step(sym_c[i], sym_d[i], e);
            apply("rnd", 1'b1, sym_c[i], sym_d[i], e);
        end
`ifdef RX_FRAMER_STATS_EN
        chk("stats.pkt_count", 32'(pkt_count), 32'(m_pkt));
        chk("stats.err_count", 32'(err_count), 32'(m_err));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
